uart_tx_buffer: RTL and testbench

UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_tx_buffer_if.sv | 35 +++
 rtl/sync_fifo.sv | 76 +++++++
 rtl/uart_tx_buffer.sv | 121 ++++++++++++
 tb/tb_uart_tx_buffer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit buffer.
package uart_pkg;

    localparam int unsigned UART_DATA_W        = 8;
    localparam int unsigned TXBUF_DEPTH        = 16;
    localparam int unsigned TXBUF_BUSY_TIMEOUT = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_buf_state_t;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Core-store / transmitter signal bundle around the UART transmit buffer.
// master: the surrounding system (core store path plus transmitter).
// slave:  the buffer itself.
interface uart_tx_buffer_if
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = TXBUF_DEPTH
) ();

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                   wr_en;
    logic [UART_DATA_W-1:0] wr_data;
    logic                   flush;
    logic                   clr_overflow;
    logic                   full;
    logic                   empty;
    logic [CNT_W-1:0]       count;
    logic                   overflow;
    logic                   tx_idle;
    logic [UART_DATA_W-1:0] uart_data;
    logic                   uart_we;
    logic                   uart_busy;

    modport master (
        output wr_en, wr_data, flush, clr_overflow, uart_busy,
        input  full, empty, count, overflow, tx_idle, uart_data, uart_we
    );

    modport slave (
        input  wr_en, wr_data, flush, clr_overflow, uart_busy,
        output full, empty, count, overflow, tx_idle, uart_data, uart_we
    );

endinterface

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO: registered count/full/empty, combinational head read.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       empty_next_c
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count_next;
    logic              push_ok;
    logic              pop_ok;

    // Full/empty gate on the current count, so a same-cycle pop never admits a write.
    assign push_ok = push && !full && !flush;
    assign pop_ok  = pop && !empty && !flush;
    assign rd_data = mem[rd_ptr];

    // Next occupancy; flush empties the queue outright.
    always_comb begin
        count_next = count;
        if (flush) begin
            count_next = '0;
        end else if (push_ok && !pop_ok) begin
            count_next = count + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_next = count - CNT_W'(1);
        end
    end

    assign empty_next_c = (count_next == '0);

    // Pointers and status flags; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // Storage array, deliberately not reset.
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Transmit queue between the core store path and the UART transmitter,
// feeding one byte at a time through a send/busy handshake.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH        = TXBUF_DEPTH,
    parameter int unsigned BUSY_TIMEOUT = TXBUF_BUSY_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    uart_tx_buffer_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned TMR_W = $clog2(BUSY_TIMEOUT + 1);

    tx_buf_state_t          state;
    tx_buf_state_t          state_next;
    logic [TMR_W-1:0]       timer;
    logic [TMR_W-1:0]       timer_next;
    logic                   pop_c;
    logic                   push_c;
    logic                   ovf_set_c;
    logic [UART_DATA_W-1:0] fifo_rd_data;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_empty_next_c;

    // Flush beats a same-cycle write: the byte is discarded without flagging overflow.
    assign push_c    = bus.wr_en && !fifo_full && !bus.flush;
    assign ovf_set_c = bus.wr_en &&  fifo_full && !bus.flush;

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush        (bus.flush),
        .push         (push_c),
        .pop          (pop_c),
        .wr_data      (bus.wr_data),
        .rd_data      (fifo_rd_data),
        .count        (fifo_count),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .empty_next_c (fifo_empty_next_c)
    );

    assign bus.count = fifo_count;
    assign bus.full  = fifo_full;
    assign bus.empty = fifo_empty;

    // Send handshake: pop head, pulse send, wait for busy to rise (bounded), then fall.
    always_comb begin
        state_next = state;
        timer_next = timer;
        pop_c      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !bus.uart_busy && !bus.flush) begin
                    pop_c      = 1'b1;
                    state_next = SEND;
                end
            end
            SEND: begin
                timer_next = '0;
                state_next = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (bus.uart_busy) begin
                    state_next = WAIT_DONE;
                end else if (timer == TMR_W'(BUSY_TIMEOUT - 1)) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer + TMR_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!bus.uart_busy) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, timer and registered transmitter-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            bus.uart_we   <= 1'b0;
            bus.uart_data <= '0;
            bus.tx_idle   <= 1'b1;
        end else begin
            state       <= state_next;
            timer       <= timer_next;
            bus.uart_we <= (state_next == SEND);
            if (pop_c) begin
                bus.uart_data <= fifo_rd_data;
            end
            bus.tx_idle <= fifo_empty_next_c && (state_next == IDLE);
        end
    end

    // Sticky overflow; a new drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.overflow <= 1'b0;
        end else if (ovf_set_c) begin
            bus.overflow <= 1'b1;
        end else if (bus.clr_overflow) begin
            bus.overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a simple transmitter busy model.
module tb_uart_tx_buffer;

    logic clk;
    logic rst;

    uart_tx_buffer_if #(.DEPTH(16)) bus ();

    uart_tx_buffer #(.DEPTH(16), .BUSY_TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    // transmitter model controls
    logic        force_busy = 1'b0;
    int unsigned model_len  = 0;
    int unsigned busy_cnt   = 0;

    // monitor records
    logic [7:0]  rx_q[$];
    int unsigned we_cyc[$];
    int unsigned cyc       = 0;
    int unsigned we_count  = 0;
    int unsigned max_cnt   = 0;

    assign bus.uart_busy = force_busy || (busy_cnt != 0);

    // Transmitter model and monitor: capture each send pulse, then hold busy.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (bus.count > max_cnt) max_cnt = bus.count;
        if (bus.uart_we) begin
            rx_q.push_back(bus.uart_data);
            we_cyc.push_back(cyc);
            we_count = we_count + 1;
            busy_cnt <= model_len;
        end else if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, need finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (got !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int unsigned bound);
        for (int i = 0; i < bound; i++) begin
            if (bus.tx_idle) break;
            tick();
        end
        check(tag, bus.tx_idle, 1);
    endtask

    task automatic wait_rx(input string tag, input int unsigned need, input int unsigned bound);
        for (int i = 0; i < bound; i++) begin
            if (rx_q.size() >= need) break;
            tick();
        end
        check(tag, rx_q.size(), need);
    endtask

    task automatic write_byte(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick();
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        int unsigned base;
        int unsigned we_base;
        logic [7:0]  exp_b;

        rst              = 1'b1;
        bus.wr_en        = 1'b0;
        bus.wr_data      = '0;
        bus.flush        = 1'b0;
        bus.clr_overflow = 1'b0;
        tick();
        tick();

        // reset state
        check("rst_count",    bus.count,     0);
        check("rst_empty",    bus.empty,     1);
        check("rst_full",     bus.full,      0);
        check("rst_overflow", bus.overflow,  0);
        check("rst_tx_idle",  bus.tx_idle,   1);
        check("rst_uart_we",  bus.uart_we,   0);
        check("rst_data",     bus.uart_data, 0);
        rst = 1'b0;
        tick();

        // single byte latency
        model_len = 10;
        base = rx_q.size();
        write_byte(8'h41);
        check("single_cnt_n1", bus.count,   1);
        check("single_we_n1",  bus.uart_we, 0);
        tick();
        check("single_we_n2",   bus.uart_we,   1);
        check("single_data_n2", bus.uart_data, 8'h41);
        check("single_cnt_n2",  bus.count,     0);
        tick();
        check("single_we_once", bus.uart_we, 0);
        wait_idle("single_idle", 40);
        check("single_rx_n",    rx_q.size() - base, 1);
        check("single_rx_byte", rx_q[base], 8'h41);

        // fill with busy held high, then overflow race
        force_busy = 1'b1;
        for (int i = 0; i < 17; i++) write_byte(8'(i));
        check("fill_count",    bus.count,    16);
        check("fill_full",     bus.full,     1);
        check("fill_overflow", bus.overflow, 1);
        bus.wr_en = 1'b1; bus.wr_data = 8'h99; bus.clr_overflow = 1'b1;
        tick();
        bus.wr_en = 1'b0;
        check("race_ovf_held", bus.overflow, 1);
        check("race_count",    bus.count,    16);
        tick();
        bus.clr_overflow = 1'b0;
        check("race_ovf_clr", bus.overflow, 0);
        base = rx_q.size();
        model_len  = 2;
        force_busy = 1'b0;
        wait_rx("fill_rx_n", base + 16, 400);
        for (int i = 0; i < 16; i++) check($sformatf("fill_rx_%0d", i), rx_q[base+i], 8'(i));
        wait_idle("fill_idle", 40);

        // stream 40 bytes through a 3-cycle transmitter
        model_len = 3;
        base = rx_q.size();
        for (int i = 0; i < 40; i++) begin
            for (int g = 0; g < 100; g++) begin
                if (!bus.full) break;
                tick();
            end
            write_byte(8'(i * 7 + 3));
        end
        wait_rx("wrap_rx_n", base + 40, 2000);
        for (int i = 0; i < 40; i++) begin
            exp_b = 8'(i * 7 + 3);
            check($sformatf("wrap_rx_%0d", i), rx_q[base+i], exp_b);
        end
        check("wrap_max_count", (max_cnt <= 16), 1);
        check("wrap_overflow",  bus.overflow, 0);
        wait_idle("wrap_idle", 40);

        // flush during WAIT_DONE
        model_len = 20;
        base    = rx_q.size();
        we_base = we_count;
        for (int i = 0; i < 5; i++) write_byte(8'hA0 + 8'(i));
        for (int i = 0; i < 20; i++) begin
            if (bus.uart_busy) break;
            tick();
        end
        check("flush_busy_seen", bus.uart_busy, 1);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_count", bus.count, 0);
        check("flush_empty", bus.empty, 1);
        wait_idle("flush_idle", 60);
        for (int i = 0; i < 10; i++) tick();
        check("flush_we_n",   we_count - we_base, 1);
        check("flush_rx_byte", rx_q[base], 8'hA0);

        // flush wins over a write while full
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) write_byte(8'h55);
        check("fw_count_full", bus.count, 16);
        bus.flush = 1'b1; bus.wr_en = 1'b1; bus.wr_data = 8'h66;
        tick();
        bus.flush = 1'b0; bus.wr_en = 1'b0;
        check("fw_overflow", bus.overflow, 0);
        check("fw_count",    bus.count,    0);
        force_busy = 1'b0;
        tick();

        // busy tied low: timeout spacing between sends
        model_len = 0;
        base = rx_q.size();
        for (int i = 0; i < 3; i++) write_byte(8'hC0 + 8'(i));
        wait_rx("to_rx_n", base + 3, 100);
        check("to_gap_01", we_cyc[base+1] - we_cyc[base], 6);
        check("to_gap_12", we_cyc[base+2] - we_cyc[base+1], 6);
        check("to_byte_0", rx_q[base],   8'hC0);
        check("to_byte_2", rx_q[base+2], 8'hC2);
        wait_idle("to_idle", 40);

        // reset mid-transmission
        model_len = 5;
        for (int i = 0; i < 3; i++) write_byte(8'hE0 + 8'(i));
        for (int i = 0; i < 10; i++) begin
            if (bus.uart_we) break;
            tick();
        end
        check("rstmid_we_seen", bus.uart_we, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rstmid_we",      bus.uart_we,   0);
        check("rstmid_count",   bus.count,     0);
        check("rstmid_tx_idle", bus.tx_idle,   1);
        check("rstmid_data",    bus.uart_data, 0);
        we_base = we_count;
        for (int i = 0; i < 20; i++) tick();
        check("rstmid_no_we", we_count - we_base, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
